// File: rtl/dht11_pkg.sv
// dht11_pkg: shared states, frame layout and nominal sensor phase timing for the DHT11 reader
package dht11_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START_LOW,
        ST_WAIT_RESP,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_CHECK,
        ST_ERROR
    } state_e;

    localparam int FRAME_W      = 40;
    localparam int HUM_OFS      = 32;
    localparam int HUM_DEC_OFS  = 24;
    localparam int TEMP_OFS     = 16;
    localparam int TEMP_DEC_OFS = 8;
    localparam int SUM_OFS      = 0;

    localparam int RESP_WAIT_US = 30;
    localparam int RESP_LOW_US  = 80;
    localparam int RESP_HIGH_US = 80;
    localparam int BIT_LOW_US   = 50;
    localparam int BIT0_HIGH_US = 26;
    localparam int BIT1_HIGH_US = 70;

    function automatic logic [7:0] frame_sum(input logic [FRAME_W-1:0] f);
        return f[HUM_OFS+:8] + f[HUM_DEC_OFS+:8] + f[TEMP_OFS+:8] + f[TEMP_DEC_OFS+:8];
    endfunction

endpackage

// File: rtl/dht11_tick.sv
// dht11_tick: 1 us and 1 ms single-cycle strobes from CLK_HZ, restartable so poll timing is exact
module dht11_tick #(
    parameter int CLK_HZ = 50000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic us_o,
    output logic ms_o
);
    localparam int DIV = CLK_HZ / 1000000;

    logic [15:0] div_q, div_d;
    logic [9:0]  ms_q, ms_d;

    always_comb begin
        us_o  = div_q == 16'(DIV - 1);
        ms_o  = us_o && ms_q == 10'd999;
        div_d = (clr_i || us_o) ? '0 : div_q + 16'd1;
        ms_d  = (clr_i || ms_o) ? '0 : ms_q + {9'd0, us_o};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_q <= '0;
            ms_q  <= '0;
        end else begin
            div_q <= div_d;
            ms_q  <= ms_d;
        end
    end

endmodule

// File: rtl/dht11_reader.sv
// dht11_reader: periodic DHT11 single-wire master with checksum-verified temperature/humidity bytes
module dht11_reader
    import dht11_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int POLL_MS       = 2000,
    parameter int START_MS      = 18,
    parameter int BIT_THRESH_US = 40,
    parameter int TIMEOUT_US    = 200
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    inout  wire        w1_o,
    output logic [7:0] temp_o,
    output logic [7:0] hum_o,
    output logic       valid_o,
    output logic       err_o,
    output logic       w1_d
);
    state_e              state_q, state_d;
    logic [7:0]          us_q, us_d, us_inc;
    logic [15:0]         poll_q, poll_d;
    logic [5:0]          idx_q, idx_d;
    logic [FRAME_W-1:0]  sr_q, sr_d;
    logic [7:0]          temp_q, temp_d, hum_q, hum_d;
    logic                valid_q, valid_d, err_q, err_d;
    logic [2:0]          sync_q, sync_d;
    logic                us_tick, ms_tick, clr, rise, fall, timeout;

    dht11_tick #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (clr),
        .us_o  (us_tick),
        .ms_o  (ms_tick)
    );

    assign w1_o = (state_q == ST_START_LOW) ? 1'b0 : 1'bz;

    always_comb begin
        sync_d  = {sync_q[1:0], w1_o};
        rise    = sync_q[1] & ~sync_q[2];
        fall    = ~sync_q[1] & sync_q[2];
        us_inc  = (us_q == 8'hFF) ? us_q : us_q + {7'd0, us_tick};
        timeout = us_inc >= 8'(TIMEOUT_US);
        state_d = state_q;
        poll_d  = poll_q + 16'(ms_tick && poll_q != 16'hFFFF);
        idx_d   = idx_q;
        sr_d    = sr_q;
        temp_d  = temp_q;
        hum_d   = hum_q;
        valid_d = 1'b0;
        err_d   = err_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: if (ms_tick && poll_q >= 16'(POLL_MS - 1)) begin
                state_d = ST_START_LOW;
                poll_d  = '0;
                clr     = 1'b1;
            end
            ST_START_LOW: if (ms_tick && poll_q == 16'(START_MS - 1)) state_d = ST_WAIT_RESP;
            ST_WAIT_RESP: state_d = fall ? ST_RESP_LOW : timeout ? ST_ERROR : state_q;
            ST_RESP_LOW:  state_d = rise ? ST_RESP_HIGH : timeout ? ST_ERROR : state_q;
            ST_RESP_HIGH: begin
                state_d = fall ? ST_BIT_LOW : timeout ? ST_ERROR : state_q;
                idx_d   = '0;
            end
            ST_BIT_LOW:   state_d = rise ? ST_BIT_HIGH : timeout ? ST_ERROR : state_q;
            ST_BIT_HIGH: if (fall) begin
                // us_inc includes the edge cycle, so a bit held exactly BIT_THRESH_US decodes as 0
                sr_d    = {sr_q[FRAME_W-2:0], us_inc > 8'(BIT_THRESH_US)};
                idx_d   = idx_q + 6'd1;
                state_d = (idx_q == 6'(FRAME_W - 1)) ? ST_CHECK : ST_BIT_LOW;
            end else if (timeout) begin
                state_d = ST_ERROR;
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (frame_sum(sr_q) == sr_q[SUM_OFS+:8]) begin
                    hum_d   = sr_q[HUM_OFS+:8];
                    temp_d  = sr_q[TEMP_OFS+:8];
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
            ST_ERROR: begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        us_d = (state_d != state_q) ? '0 : us_inc;
        w1_d = state_q inside {ST_START_LOW, ST_WAIT_RESP, ST_RESP_LOW, ST_RESP_HIGH,
                               ST_BIT_LOW, ST_BIT_HIGH, ST_CHECK};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            us_q    <= '0;
            poll_q  <= '0;
            idx_q   <= '0;
            sr_q    <= '0;
            temp_q  <= '0;
            hum_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            sync_q  <= 3'b111;
        end else begin
            state_q <= state_d;
            us_q    <= us_d;
            poll_q  <= poll_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            temp_q  <= temp_d;
            hum_q   <= hum_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            sync_q  <= sync_d;
        end
    end

    assign temp_o  = temp_q;
    assign hum_o   = hum_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_dht11_reader.sv
// tb_dht11_reader: sensor model drives frames, scoreboard checks outputs at the end of each transfer
module tb_dht11_reader;
    import dht11_pkg::*;

    localparam int POLL_CYC  = 7000;
    localparam int START_CYC = 1000;

    typedef struct {
        logic [7:0] hum;
        logic [7:0] temp;
        logic       err;
        int         nvalid;
    } exp_t;

    logic       clk = 1'b0, rst_ni = 1'b0, sensor_low = 1'b0;
    logic [7:0] temp, hum;
    logic       valid, err, busy;
    wire        w1;

    assign w1 = sensor_low ? 1'b0 : 1'bz;
    pullup (w1);

    dht11_reader #(
        .CLK_HZ(1000000), .POLL_MS(7), .START_MS(1), .BIT_THRESH_US(40), .TIMEOUT_US(200)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .w1_o(w1), .temp_o(temp), .hum_o(hum),
        .valid_o(valid), .err_o(err), .w1_d(busy)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0, vcnt = 0, bad_drv = 0, prev_t = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) vcnt++;
        if (sensor_low && w1 !== 1'b0) bad_drv++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] h, input logic [7:0] t, input logic e, input int n);
        exp_t r;
        r.hum = h; r.temp = t; r.err = e; r.nvalid = n;
        return r;
    endfunction

    initial begin
        int   seen;
        exp_t e;
        seen = 0;
        wait (mon_en);
        forever begin
            @(negedge busy);
            repeat (3) @(posedge clk);
            #1;
            if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                chk("hum", {24'd0, hum}, {24'd0, e.hum});
                chk("temp", {24'd0, temp}, {24'd0, e.temp});
                chk("err", {31'd0, err}, {31'd0, e.err});
                chk("valid_pulses", vcnt - seen, e.nvalid);
            end
            seen = vcnt;
        end
    end

    task automatic poll(input logic [39:0] f, input bit respond, input bit edgy,
                        input int abort_bit, input exp_t e);
        int n, lo, hi;
        bit b;
        exp_q.push_back(e);
        n = 0;
        while (!busy && n < POLL_CYC + 100) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", {31'd0, busy}, 1);
        chk("poll_interval", cyc - prev_t, POLL_CYC);
        prev_t = cyc;
        lo = 0;
        while (w1 == 1'b0 && lo < 3 * START_CYC) begin
            lo++;
            @(negedge clk);
        end
        chk("start_len", lo, START_CYC);
        if (!respond) begin
            repeat (300) @(negedge clk);
            return;
        end
        repeat (RESP_WAIT_US) @(negedge clk);
        sensor_low = 1'b1;
        repeat (RESP_LOW_US) @(negedge clk);
        sensor_low = 1'b0;
        repeat (RESP_HIGH_US) @(negedge clk);
        for (int i = 0; i < FRAME_W; i++) begin
            b = f[FRAME_W-1-i];
            sensor_low = 1'b1;
            repeat (BIT_LOW_US) @(negedge clk);
            sensor_low = 1'b0;
            hi = b ? ((edgy && i % 2 == 1) ? 41 : BIT1_HIGH_US)
                   : ((edgy && i % 2 == 1) ? 40 : BIT0_HIGH_US);
            if (i == abort_bit) begin
                repeat (10) @(negedge clk);
                rst_ni = 1'b0;
                @(negedge clk);
                prev_t = cyc;
                rst_ni = 1'b1;
                chk("rst_busy", {31'd0, busy}, 0);
                chk("rst_wire", {31'd0, w1}, 1);
                return;
            end
            repeat (hi) @(negedge clk);
        end
        sensor_low = 1'b1;
        repeat (BIT_LOW_US) @(negedge clk);
        sensor_low = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_temp", {24'd0, temp}, 0);
        chk("rst_hum", {24'd0, hum}, 0);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_w1_d", {31'd0, busy}, 0);
        chk("rst_w1_released", {31'd0, w1}, 1);
        prev_t = cyc;
        rst_ni = 1'b1;
        mon_en = 1'b1;
        poll(40'h37_00_19_00_50, 1'b1, 1'b0, -1, mk(8'h37, 8'h19, 1'b0, 1));
        poll(40'h28_00_1E_00_47, 1'b1, 1'b0, -1, mk(8'h37, 8'h19, 1'b1, 0));
        poll(40'h0,              1'b0, 1'b0, -1, mk(8'h37, 8'h19, 1'b1, 0));
        poll(40'h2D_05_16_03_4B, 1'b1, 1'b0, -1, mk(8'h2D, 8'h16, 1'b0, 1));
        poll(40'h37_00_1A_00_51, 1'b1, 1'b1, -1, mk(8'h37, 8'h1A, 1'b0, 1));
        poll(40'h37_00_19_00_50, 1'b1, 1'b0, 20, mk(8'h00, 8'h00, 1'b0, 0));
        poll(40'h5A_C8_1E_64_A4, 1'b1, 1'b0, -1, mk(8'h5A, 8'h1E, 1'b0, 1));
        repeat (200) @(negedge clk);
        chk("sb_drain", exp_q.size(), 0);
        chk("w1_drive_conflict", bad_drv, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
